data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory interface: the MEM stage issues load/store requests; this block accepts them, models a fixed multi-cycle access latency, commits writes and returns read data.
- Replaces the zero-latency memory with a request/response handshake so the pipeline can stall on memory.
- Holds one outstanding request at a time.

Parameters:
- ADDR_W, 16, request address width (word address).
- DATA_W, 32, data word width, matches the register file.
- DEPTH, 1024, number of words implemented; addresses >= DEPTH are out of range.
- LATENCY, 2, cycles from accept to response; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- flush  in  1  pipeline flush from execute.
- resp_valid  out  1  one-cycle pulse: response available.
- resp_rdata  out  DATA_W  load data, valid with resp_valid.
- resp_err  out  1  out-of-range address, valid with resp_valid.
- stall  out  1  req_valid & ~req_ready, or request outstanding; holds the pipeline.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0, counter=0.
  - Memory contents are NOT reset.
- FSM states IDLE, BUSY, RESP:
  - IDLE: req_ready=1. Accept when req_valid & ~flush. On accept, latch we/addr/wdata. Go to RESP if LATENCY==1, else BUSY with counter=LATENCY-1.
  - IDLE with req_valid & flush: request is not accepted; stay IDLE.
  - BUSY: req_ready=0. Counter decrements each cycle; at counter==1, go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Latency: request accepted at edge T gives resp_valid high in cycle T+LATENCY. Throughput is one request per LATENCY+1 cycles.
- Writes:
  - Committed to the array on the clock edge that enters RESP. A store response carries resp_rdata=0.
  - A load to the same address issued afterwards returns the new value.
- Reads: array read occurs on entry to RESP; resp_rdata is registered and holds its value until the next response.
- Out of range (addr >= DEPTH):
  - Write is dropped; resp_rdata=0; resp_err=1 with resp_valid.
  - Address is compared at full ADDR_W, so there is no wrap-around.
- Flush while BUSY:
  - An outstanding load is cancelled: return to IDLE next cycle, no resp_valid.
  - An outstanding store is NOT cancelled and completes normally.
- Flush in RESP: ignored; the response is still emitted.
- stall = (state!=IDLE) | (req_valid & ~req_ready). This reduces to (state!=IDLE) while a request is pending.
- Reset mid-operation:
  - Outstanding request discarded; an uncommitted store is NOT written.
  - No resp_valid is emitted; return to IDLE.
- req_* inputs are ignored outside IDLE. Changes while BUSY do not affect the latched request.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Default widths (ADDR_W=16, DATA_W=32).
  - Counter width constant (4 bits).
- One sub-module, data_mem_array:
  - Single-port synchronous RAM, DEPTH x DATA_W, with we/addr/wdata/rdata.
  - No reset on contents.
  - Instantiated once inside data_mem_responder.

Test Plan:
- Reset, then store addr 0x0005 data 0xDEADBEEF → accept at T, resp_valid at T+2 with resp_err=0, rdata=0. Load 0x0005 → resp_rdata=0xDEADBEEF two cycles after its accept.
- Back-to-back requests held on req_valid → req_ready low for 2 cycles after each accept; stall high throughout. Second request is accepted the cycle after the first resp_valid.
- Load addr 0x0400 (DEPTH=1024) → resp_err=1, resp_rdata=0. Store to 0x0400, then load 0x0000 → address 0 contents unchanged, showing no wrap.
- Load accepted, flush pulsed the next cycle → no resp_valid, IDLE next cycle. Repeat with a store plus flush → resp_valid still fires, and a later load returns the stored value.
- Store 0x12345678 to 0x0010 accepted, rst asserted one cycle later → outputs return to reset values next edge, no resp_valid. Later load 0x0010 returns its prior value.
- LATENCY=1 build → resp_valid exactly one cycle after accept. Load after store to the same address returns the new data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              flush;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM; contents are never reset, read data holds between reads.
module data_mem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles, then
// commits the write or returns read data with a one-cycle response pulse.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rd_sel_q, rd_sel_d;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              in_range;
    logic              enter_resp;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    // With LATENCY==1 the RAM is accessed on the accept edge itself, so it must see the live request.
    assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign in_range  = 32'(cur_addr) < DEPTH;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rd_sel_d   = rd_sel_q;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (bus.flush && !we_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            err_d    = !in_range;
            rd_sel_d = in_range && !cur_we;
        end
    end

    // Reset must also block the commit of a store that would otherwise enter RESP on this edge.
    assign ram_en = enter_resp && in_range && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    data_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (cur_we),
        .addr  (cur_addr[RAM_AW-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rd_sel_q ? ram_rdata : '0;
    assign bus.resp_err   = err_q;
    assign bus.stall      = (state_q != IDLE) || (bus.req_valid && !bus.req_ready);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance checked against a word-array model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        v    [2];
    logic        we_i [2];
    logic [15:0] a    [2];
    logic [31:0] wdv  [2];
    logic        fl   [2];
    logic        rdy  [2];
    logic        rv   [2];
    logic        er   [2];
    logic        st   [2];
    logic [31:0] rd   [2];

    data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) b2 ();
    data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) b1 ();

    assign b2.req_valid = v[0];
    assign b2.req_we    = we_i[0];
    assign b2.req_addr  = a[0];
    assign b2.req_wdata = wdv[0];
    assign b2.flush     = fl[0];
    assign rdy[0] = b2.req_ready;
    assign rv[0]  = b2.resp_valid;
    assign er[0]  = b2.resp_err;
    assign st[0]  = b2.stall;
    assign rd[0]  = b2.resp_rdata;

    assign b1.req_valid = v[1];
    assign b1.req_we    = we_i[1];
    assign b1.req_addr  = a[1];
    assign b1.req_wdata = wdv[1];
    assign b1.flush     = fl[1];
    assign rdy[1] = b1.req_ready;
    assign rv[1]  = b1.resp_valid;
    assign er[1]  = b1.resp_err;
    assign st[1]  = b1.stall;
    assign rd[1]  = b1.resp_rdata;

    data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk (clk),
        .rst (rst[0]),
        .bus (b2)
    );

    data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst[1]),
        .bus (b1)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [31:0] ref_mem   [2][DEPTH];
    bit          ref_known [2][DEPTH];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reset_chk(input int s, input string tag);
        chk({tag, ":ready"}, 32'(rdy[s]), 32'd1);
        chk({tag, ":valid"}, 32'(rv[s]), 32'd0);
        chk({tag, ":rdata"}, rd[s], 32'd0);
        chk({tag, ":err"},   32'(er[s]), 32'd0);
        chk({tag, ":stall"}, 32'(st[s]), 32'd0);
    endtask

    // One request with the model's expectations; fl_in pulses flush the cycle after accept.
    task automatic txn(input int s, input bit we, input logic [15:0] addr,
                       input logic [31:0] wd, input bit fl_in, input string tag);
        bit          exp_err, cancel, got, busy_ok, idle_after_cancel;
        int          lat;
        logic [31:0] exp_rd;
        bit          rd_known;
        exp_err  = (32'(addr) >= DEPTH);
        cancel   = fl_in && !we && (lat_of(s) > 1);
        exp_rd   = '0;
        rd_known = 1'b1;
        if (!we && !exp_err) begin
            exp_rd   = ref_mem[s][addr[9:0]];
            rd_known = ref_known[s][addr[9:0]];
        end
        @(negedge clk);
        chk({tag, ":idle"}, {30'd0, rdy[s], rv[s]}, 32'd2);
        v[s] = 1'b1; we_i[s] = we; a[s] = addr; wdv[s] = wd;
        @(posedge clk);
        got = 1'b0; lat = 0; busy_ok = 1'b1; idle_after_cancel = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (rv[s]) begin
                got = 1'b1;
                lat = i;
                busy_ok &= (rdy[s] == 1'b0) && (st[s] == 1'b1);
            end else if (cancel && i == 2) begin
                idle_after_cancel = rdy[s];
            end else if (!(cancel && i > 2)) begin
                busy_ok &= (rdy[s] == 1'b0) && (st[s] == 1'b1);
            end
            v[s]  = 1'b0;
            fl[s] = (i == 1) ? fl_in : 1'b0;
        end
        fl[s] = 1'b0;
        if (cancel) begin
            chk({tag, ":no_resp"}, 32'(got), 32'd0);
            chk({tag, ":idle_next"}, 32'(idle_after_cancel), 32'd1);
        end else begin
            chk({tag, ":resp_seen"}, 32'(got), 32'd1);
            chk({tag, ":latency"}, 32'(lat), 32'(lat_of(s)));
            chk({tag, ":busy"}, 32'(busy_ok), 32'd1);
            if (got) begin
                chk({tag, ":err"}, 32'(er[s]), 32'(exp_err));
                if (rd_known) chk({tag, ":rdata"}, rd[s], exp_rd);
            end
        end
        if (we && !exp_err) begin
            ref_mem[s][addr[9:0]]   = wd;
            ref_known[s][addr[9:0]] = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; v[s] = 1'b0; we_i[s] = 1'b0; a[s] = '0; wdv[s] = '0; fl[s] = 1'b0;
            for (int k = 0; k < int'(DEPTH); k++) ref_known[s][k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_chk(0, "reset2");
        reset_chk(1, "reset1");
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Basic store/load on the LATENCY=2 instance.
        txn(0, 1'b1, 16'h0005, 32'hDEADBEEF, 1'b0, "st5");
        txn(0, 1'b0, 16'h0005, 32'h0,        1'b0, "ld5");
        txn(0, 1'b1, 16'h0000, 32'h0BADF00D, 1'b0, "st0");
        txn(0, 1'b1, 16'h0010, 32'hA5A50010, 1'b0, "st10");

        // Back-to-back with req_valid held high across both requests.
        @(negedge clk);
        v[0] = 1'b1; we_i[0] = 1'b1; a[0] = 16'h0020; wdv[0] = 32'h5566_7788;
        @(posedge clk);
        @(negedge clk);
        chk("b2b:t1_ready", 32'(rdy[0]), 32'd0);
        chk("b2b:t1_stall", 32'(st[0]), 32'd1);
        chk("b2b:t1_valid", 32'(rv[0]), 32'd0);
        we_i[0] = 1'b0; wdv[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("b2b:t2_ready", 32'(rdy[0]), 32'd0);
        chk("b2b:t2_valid", 32'(rv[0]), 32'd1);
        chk("b2b:t2_stall", 32'(st[0]), 32'd1);
        chk("b2b:t2_rdata", rd[0], 32'd0);
        ref_mem[0][16'h0020] = 32'h5566_7788; ref_known[0][16'h0020] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b:t3_ready", 32'(rdy[0]), 32'd1);
        chk("b2b:t3_valid", 32'(rv[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b:t4_accepted", 32'(rdy[0]), 32'd0);
        v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b:t5_valid", 32'(rv[0]), 32'd1);
        chk("b2b:t5_rdata", rd[0], 32'h5566_7788);

        // Out of range, and no wrap-around onto address 0.
        txn(0, 1'b0, 16'h0400, 32'h0,        1'b0, "ld400");
        txn(0, 1'b1, 16'h0400, 32'hFFFFFFFF, 1'b0, "st400");
        txn(0, 1'b0, 16'h0000, 32'h0,        1'b0, "ld0_nowrap");

        // Flush: cancels an outstanding load, blocks acceptance in IDLE, spares a store.
        txn(0, 1'b0, 16'h0005, 32'h0, 1'b1, "ld_flush");
        @(negedge clk);
        v[0] = 1'b1; we_i[0] = 1'b1; a[0] = 16'h0005; wdv[0] = 32'h1; fl[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_flush:not_accepted", 32'(rdy[0]), 32'd1);
        v[0] = 1'b0; fl[0] = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ok &= (rv[0] == 1'b0);
        end
        chk("idle_flush:no_resp", 32'(ok), 32'd1);
        txn(0, 1'b0, 16'h0005, 32'h0,        1'b0, "ld5_after_idle_flush");
        txn(0, 1'b1, 16'h0030, 32'hCAFEF00D, 1'b1, "st_flush");
        txn(0, 1'b0, 16'h0030, 32'h0,        1'b0, "ld30");

        // Reset one cycle after a store is accepted: store must not land.
        @(negedge clk);
        v[0] = 1'b1; we_i[0] = 1'b1; a[0] = 16'h0010; wdv[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0; rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_chk(0, "midrst");
        rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst:no_resp", 32'(rv[0]), 32'd0);
        txn(0, 1'b0, 16'h0010, 32'h0, 1'b0, "ld10_prior");

        // LATENCY=1 instance.
        txn(1, 1'b1, 16'h0007, 32'h11112222, 1'b0, "l1_st7a");
        txn(1, 1'b0, 16'h0007, 32'h0,        1'b0, "l1_ld7a");
        txn(1, 1'b1, 16'h0007, 32'h33334444, 1'b0, "l1_st7b");
        txn(1, 1'b0, 16'h0007, 32'h0,        1'b0, "l1_ld7b");
        txn(1, 1'b1, 16'h0400, 32'h99999999, 1'b0, "l1_st400");
        txn(1, 1'b0, 16'hFFFF, 32'h0,        1'b0, "l1_ldFFFF");
        txn(1, 1'b1, 16'h0008, 32'h0F0F0F0F, 1'b1, "l1_st8_flush");
        txn(1, 1'b0, 16'h0008, 32'h0,        1'b1, "l1_ld8_flush");

        // Randomized traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                bit          rwe, rfl;
                logic [15:0] raddr;
                logic [31:0] rwd;
                rwe   = 1'($urandom_range(0, 1));
                raddr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535))
                                                    : 16'($urandom_range(0, 15));
                rwd   = $urandom;
                rfl   = ($urandom_range(0, 5) == 0);
                txn(s, rwe, raddr, rwd, rfl, (s == 0) ? "rnd2" : "rnd1");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
